// File: rtl/pipemem_mmio_pkg.sv
// rtl/pipemem_mmio_pkg.sv - shared word-index map and byte-merge helper for pipemem_mmio
// Purpose: I/O word-index offsets derived from the instance parameters, and the
//          byte-enable merge used by every writable location.
// Ports:   none (package).
package pipemem_mmio_pkg;

    // First I/O word index of the output registers.
    function automatic int out_base();
        return 0;
    endfunction

    // First I/O word index of the input ports; they follow the outputs.
    function automatic int in_base(input int n_out);
        return n_out;
    endfunction

    // Word index of the sticky change-status register.
    function automatic int status_idx(input int n_out, input int n_in);
        return n_out + n_in;
    endfunction

    // Replace only the bytes whose enable bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/pipemem_mmio_if.sv
// rtl/pipemem_mmio_if.sv - request/response bus between the MEM stage and pipemem_mmio
// Purpose: bundles the request and read-response signals.
// Ports:   master drives req_*, samples resp_*; slave is the reverse.
interface pipemem_mmio_if;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output resp_valid, resp_rdata
    );
endinterface

// File: rtl/pipemem_mmio_io_in_sync.sv
// rtl/pipemem_mmio_io_in_sync.sv - one input port: two-flop synchroniser, delayed copy, sticky change flag
// Purpose: brings an asynchronous 32-bit word into the clock domain and flags any change.
// Ports:   clock, reset (sync, active-high); raw (async word); clear (status-read clear);
//          sync_data (synchronised word); flag (sticky change flag).
module io_in_sync (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] raw,
    input  logic        clear,
    output logic [31:0] sync_data,
    output logic        flag
);
    logic [31:0] sync1;
    logic [31:0] sync2;
    logic [31:0] delayed;
    logic        flag_q;
    logic        change;

    // Any bit difference between the synchronised word and its previous value.
    assign change = (sync2 != delayed);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            delayed <= '0;
            flag_q  <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            delayed <= sync2;
            // A change in the same cycle as a clearing read keeps the flag set.
            flag_q  <= change | (flag_q & ~clear);
        end
    end

    assign sync_data = sync2;
    assign flag      = flag_q;
endmodule

// File: rtl/pipemem_mmio.sv
// rtl/pipemem_mmio.sv - MEM-stage data memory: word RAM plus memory-mapped I/O window
// Purpose: byte-enabled writes, one-cycle registered reads, N_OUT output registers,
//          N_IN synchronised inputs and a clear-on-read change-status register with irq.
// Ports:   clock, reset (sync, active-high); bus (slave request/response);
//          in_port (async inputs, 32 bits per port); out_port (output registers);
//          irq (registered OR of status flags).
module pipemem_mmio
    import pipemem_mmio_pkg::*;
#(
    parameter int          DEPTH     = 32,
    parameter int          IO_BIT    = 7,
    parameter int          N_OUT     = 4,
    parameter int          N_IN      = 2,
    parameter logic [31:0] OUT_RESET = 32'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    pipemem_mmio_if.slave         bus,
    input  logic [32*N_IN-1:0]    in_port,
    output logic [32*N_OUT-1:0]   out_port,
    output logic                  irq
);
    localparam int AW         = $clog2(DEPTH);
    localparam int OUT_BASE   = out_base();
    localparam int IN_BASE    = in_base(N_OUT);
    localparam int STATUS_IDX = status_idx(N_OUT, N_IN);

    logic [31:0]   mem [DEPTH];
    logic [31:0]   out_regs [N_OUT];
    logic [31:0]   in_sync [N_IN];
    logic [N_IN-1:0] flags;
    logic [N_IN-1:0] clear;

    logic          is_io;
    logic          wr;
    logic          rd;
    logic [AW-1:0] ram_idx;
    logic [31:0]   w_idx;
    logic [31:0]   io_rdata;
    logic          status_rd;
    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q;
    logic          irq_q;

    assign is_io   = bus.req_addr[IO_BIT];
    assign wr      = bus.req_valid & bus.req_we;
    assign rd      = bus.req_valid & ~bus.req_we;
    // Upper RAM address bits are ignored, so the RAM aliases through its region.
    assign ram_idx = bus.req_addr[AW+1:2];
    assign w_idx   = 32'(bus.req_addr[IO_BIT-1:2]);

    assign status_rd = rd & is_io & (w_idx == 32'(STATUS_IDX));
    assign clear     = {N_IN{status_rd}};

    // Address bits outside the decode are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.req_addr[31:IO_BIT+1], bus.req_addr[1:0]};

    // RAM: no reset, synchronous read below.
    always_ff @(posedge clock) begin
        if (wr && !is_io) begin
            mem[ram_idx] <= byte_merge(mem[ram_idx], bus.req_wdata, bus.req_be);
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N_OUT; k++) begin
                out_regs[k] <= OUT_RESET;
            end
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (wr && is_io && (w_idx == 32'(OUT_BASE + k))) begin
                    out_regs[k] <= byte_merge(out_regs[k], bus.req_wdata, bus.req_be);
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_out
            assign out_port[32*g +: 32] = out_regs[g];
        end
        for (g = 0; g < N_IN; g++) begin : g_in
            io_in_sync u_sync (
                .clock     (clock),
                .reset     (reset),
                .raw       (in_port[32*g +: 32]),
                .clear     (clear[g]),
                .sync_data (in_sync[g]),
                .flag      (flags[g])
            );
        end
    endgenerate

    // I/O read mux; unmapped words read as zero. Status returns the pre-edge flags.
    always_comb begin
        io_rdata = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (w_idx == 32'(OUT_BASE + k)) begin
                io_rdata = out_regs[k];
            end
        end
        for (int k = 0; k < N_IN; k++) begin
            if (w_idx == 32'(IN_BASE + k)) begin
                io_rdata = in_sync[k];
            end
        end
        if (w_idx == 32'(STATUS_IDX)) begin
            io_rdata = 32'(flags);
        end
    end

    // Read response: valid exactly one cycle after the request, data held otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= rd;
            if (rd) begin
                resp_rdata_q <= is_io ? io_rdata : mem[ram_idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |flags;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign irq            = irq_q;
endmodule

// File: doc/pipemem_mmio.md
Name: pipemem_mmio

Overview:
- Parametrised successor to the single-port data memory with its one fixed I/O window.
- Single-clock, request/response data-memory slave for the pipelined CPU's MEM stage.
- Provides a word-addressed RAM region and a memory-mapped I/O region, both with byte-enable writes and registered reads.
- I/O region holds N_OUT output registers, N_IN synchronised input ports, and a sticky change-status register that drives an interrupt.

Parameters:
- DEPTH, 32, RAM depth in 32-bit words (power of 2, ≥2); AW = log2(DEPTH).
- IO_BIT, 7, address bit selecting the I/O region (1 = I/O); must exceed AW+1.
- N_OUT, 4, number of 32-bit output registers (1..8).
- N_IN, 2, number of 32-bit input ports (1..8).
- OUT_RESET, 32'h0, reset value of every output register.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  access request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  4  byte enables; be[i] covers bits 8i+7:8i.
- req_addr  in  32  byte address; bits 1:0 ignored.
- req_wdata  in  32  write data.
- resp_valid  out  1  read data valid (reads only).
- resp_rdata  out  32  read data.
- in_port  in  32*N_IN  raw asynchronous input words; port k = bits 32k+31:32k.
- out_port  out  32*N_OUT  output register contents.
- irq  out  1  OR of all status flags, registered.

Behaviour:
- Reset (synchronous, active-high; clock and reset are fixed as above):
  - out_port = OUT_RESET on all ports.
  - resp_valid = 0, resp_rdata = 0, irq = 0.
  - All synchroniser flops and status flags = 0.
  - RAM contents are not reset.
- Decode: word index w = req_addr[IO_BIT-1:2].
  - req_addr[IO_BIT] = 0: RAM, entry req_addr[AW+1:2]; upper bits ignored (alias).
  - req_addr[IO_BIT] = 1, I/O map:
    - w in 0..N_OUT-1: out_port[w], R/W.
    - w in N_OUT..N_OUT+N_IN-1: synchronised in_port[w-N_OUT], read-only; writes ignored.
    - w = N_OUT+N_IN: STATUS; bit k = change flag of input k, other bits 0; clear-on-read; writes ignored.
    - Any other w: reads return 0, writes ignored.
- Write (req_valid & req_we): only enabled bytes update at the rising edge. No response. Visible to a read issued the next cycle.
- Read (req_valid & ~req_we):
  - resp_valid = 1 and resp_rdata = data exactly one cycle later.
  - req_be ignored.
  - resp_rdata holds its last value when resp_valid = 0.
  - Back-to-back reads give back-to-back responses (full throughput, no stalls, no ready signal).
- Input path, per port:
  - Two-flop synchroniser, then a one-cycle-delayed copy.
  - Any bit difference between the synchronised value and the delayed copy sets flag[k].
  - Reads of input ports return the synchronised value.
- STATUS read:
  - Returns the flags as they stand before the edge; all flags read are cleared at that edge.
  - If a change is detected in the same cycle as the clearing read, set wins: the flag stays 1.
- irq = registered |flags; lags the flag by one cycle.
- reset asserted during a read: resp_valid = 0 the next cycle; the pending response is dropped.
- req_valid = 0: no state change except the input path.

Decomposition:
- Package pipemem_mmio_pkg holds:
  - word-index offsets (OUT_BASE = 0, IN_BASE = N_OUT, STATUS_IDX = N_OUT+N_IN) as functions of the parameters;
  - the byte-merge function (old, new, be) → merged word.
- One sub-module, io_in_sync: one port's synchroniser, delay register and sticky flag; inputs set/clear, output flag. Instantiated N_IN times by generate.
- RAM is inferred inline as a synchronous-read array.

Test Plan:
- Reset then read I/O word 0 and RAM word 5 → resp 32'h0 for the output register; RAM value is don't-care; irq = 0, out_port = 0.
- Write RAM 0x14 = 32'hDEADBEEF with be = 4'b1111, then write 32'h00000011 with be = 4'b0001, then read 0x14 → one cycle later resp_valid = 1, rdata = 32'hDEADBE11.
- Write 0x84 (I/O word 1) = 32'hA5A5A5A5 → out_port[63:32] = 32'hA5A5A5A5 after the edge; read 0x84 returns the same; write to IN_BASE is ignored.
- Drive in_port[0] 0 → 32'h3 → read of input 0 returns 3 after ≥2 cycles; flag[0] sets; irq rises one cycle after the flag; STATUS read returns 32'h1, and a second STATUS read returns 0.
- Toggle in_port[1] in the same cycle as a STATUS read → flag[1] remains 1 after the clear (set wins).
- Issue a read with reset asserted on the next edge → resp_valid = 0; later reads of unmapped I/O word 31 → rdata = 0.
